// File: rtl/freq_pkg.sv
// Shared types and constants for the multi-channel frequency scan controller.
package freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_STORE  = 3'd3,
    ST_NEXT   = 3'd4
  } state_e;

  localparam int unsigned CLK_HZ     = 32'd50_000_000;
  localparam int unsigned GATE_1S    = 32'd50_000_000;
  localparam logic [7:0]  THRESH_DEF = 8'h80;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Lowest set mask bit whose index is >= from; from=16 means nothing is left.
  function automatic pick_t pick_from(input logic [15:0] mask, input logic [4:0] from);
    pick_t p;
    p = '{found: 1'b0, idx: 4'd0};
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        p.found = 1'b1;
        p.idx   = 4'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/edge_gate_counter.sv
// Threshold compare, two-stage level pipeline and saturating rising-crossing counter.
module edge_gate_counter
  import freq_pkg::*;
#(
  parameter int            DW     = 8,
  parameter int            CW     = 32,
  parameter logic [DW-1:0] THRESH = THRESH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          cnt_en_i,
  input  logic          sample_i,
  input  logic [DW-1:0] data_i,
  output logic [CW-1:0] count_o,
  output logic          ovf_o
);

  logic          lvl_q;
  logic          lvl_d_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          edge_s;

  assign edge_s  = lvl_q & ~lvl_d_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

  // Level pipeline freezes while sampling is disabled; count holds at all-ones and flags lost edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q   <= 1'b0;
      lvl_d_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (sample_i) begin
        lvl_q   <= (data_i >= THRESH);
        lvl_d_q <= lvl_q;
      end
      if (clr_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (cnt_en_i && edge_s) begin
        if (&cnt_q) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/freq_scan_ctrl.sv
// Sequencer that time-shares one edge counter across NCH sample streams and
// hands each channel's crossing count out on a valid/ready port.
module freq_scan_ctrl
  import freq_pkg::*;
#(
  parameter int            NCH    = 4,
  parameter int            DW     = 8,
  parameter int            CW     = 32,
  parameter logic [DW-1:0] THRESH = THRESH_DEF
) (
  input  logic              aclk,
  input  logic              rstn,
  input  logic [NCH*DW-1:0] data_in,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [31:0]       gate_cycles,
  input  logic [15:0]       settle_cycles,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_chan,
  output logic [CW-1:0]     res_count,
  output logic              res_ovf,
  output logic              busy,
  output logic              done
);

  state_e        state_q;
  logic [15:0]   mask_q;
  logic          cont_q;
  logic [31:0]   gate_m1_q;
  logic [15:0]   settle_m1_q;
  logic [3:0]    chan_q;
  logic [31:0]   gate_cnt_q;
  logic [15:0]   settle_cnt_q;
  logic          res_valid_q;
  logic          busy_q;
  logic          done_q;

  logic [15:0]   mask16_s;
  logic [31:0]   gate_m1_s;
  logic [15:0]   settle_m1_s;
  pick_t         first_s;
  pick_t         next_s;
  pick_t         wrap_s;
  logic [DW-1:0] sel_sample_s;
  logic          sample_s;
  logic          cnt_en_s;
  logic          clr_s;

  // Settle is at least two cycles so both pipeline stages hold only the new channel.
  assign mask16_s    = 16'(chan_mask);
  assign gate_m1_s   = (gate_cycles == 32'd0) ? 32'd0 : gate_cycles - 32'd1;
  assign settle_m1_s = (settle_cycles < 16'd2) ? 16'd1 : settle_cycles - 16'd1;
  assign first_s     = pick_from(mask16_s, 5'd0);
  assign next_s      = pick_from(mask_q, {1'b0, chan_q} + 5'd1);
  assign wrap_s      = pick_from(mask_q, 5'd0);

  assign sample_s = (state_q == ST_SETTLE) || (state_q == ST_GATE);
  assign cnt_en_s = (state_q == ST_GATE);
  assign clr_s    = (state_q == ST_SETTLE) && (settle_cnt_q == 16'd0);

  assign res_valid = res_valid_q;
  assign res_chan  = chan_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Select the currently scanned channel's sample.
  always_comb begin
    sel_sample_s = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_sample_s = (chan_q == 4'(i)) ? data_in[i*DW +: DW] : sel_sample_s;
    end
  end

  edge_gate_counter #(
    .DW    (DW),
    .CW    (CW),
    .THRESH(THRESH)
  ) u_counter (
    .clk_i   (aclk),
    .rst_ni  (rstn),
    .clr_i   (clr_s),
    .cnt_en_i(cnt_en_s),
    .sample_i(sample_s),
    .data_i  (sel_sample_s),
    .count_o (res_count),
    .ovf_o   (res_ovf)
  );

  // Scan sequencer; abort overrides every state and suppresses done.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mask_q       <= 16'd0;
      cont_q       <= 1'b0;
      gate_m1_q    <= 32'd0;
      settle_m1_q  <= 16'd0;
      chan_q       <= 4'd0;
      gate_cnt_q   <= 32'd0;
      settle_cnt_q <= 16'd0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= ST_IDLE;
        res_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (first_s.found) begin
                mask_q       <= mask16_s;
                cont_q       <= cont;
                gate_m1_q    <= gate_m1_s;
                settle_m1_q  <= settle_m1_s;
                chan_q       <= first_s.idx;
                settle_cnt_q <= settle_m1_s;
                busy_q       <= 1'b1;
                state_q      <= ST_SETTLE;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_cnt_q == 16'd0) begin
              gate_cnt_q <= gate_m1_q;
              state_q    <= ST_GATE;
            end else begin
              settle_cnt_q <= settle_cnt_q - 16'd1;
            end
          end
          ST_GATE: begin
            if (gate_cnt_q == 32'd0) begin
              res_valid_q <= 1'b1;
              state_q     <= ST_STORE;
            end else begin
              gate_cnt_q <= gate_cnt_q - 32'd1;
            end
          end
          ST_STORE: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              state_q     <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (next_s.found) begin
              chan_q       <= next_s.idx;
              settle_cnt_q <= settle_m1_q;
              state_q      <= ST_SETTLE;
            end else if (cont_q && wrap_s.found) begin
              chan_q       <= wrap_s.idx;
              settle_cnt_q <= settle_m1_q;
              state_q      <= ST_SETTLE;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Randomized bench for freq_scan_ctrl: square-wave channels, crossing counts predicted
// from the waveform definition and the nominal settle/gate/handshake timeline.
module tb_freq_scan_ctrl;
  import freq_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              aclk = 1'b0;
  logic              rstn = 1'b0;
  logic [NCH*DW-1:0] data_in = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              cont = 1'b0;
  logic [NCH-1:0]    chan_mask = '0;
  logic [31:0]       gate_cycles = 32'd0;
  logic [15:0]       settle_cycles = 16'd0;
  logic              res_ready = 1'b0;

  logic              res_valid, busy, done, res_ovf;
  logic [3:0]        res_chan;
  logic [31:0]       res_count;
  logic              res_valid4, busy4, done4, res_ovf4;
  logic [3:0]        res_chan4;
  logic [3:0]        res_count4;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit in_run = 1'b0;
  int per[NCH];
  int ph[NCH];

  always #10 aclk = ~aclk;

  freq_scan_ctrl #(.NCH(NCH), .DW(DW), .CW(32)) dut (
    .aclk(aclk), .rstn(rstn), .data_in(data_in), .start(start), .abort(abort),
    .cont(cont), .chan_mask(chan_mask), .gate_cycles(gate_cycles),
    .settle_cycles(settle_cycles), .res_valid(res_valid), .res_ready(res_ready),
    .res_chan(res_chan), .res_count(res_count), .res_ovf(res_ovf), .busy(busy), .done(done)
  );

  freq_scan_ctrl #(.NCH(NCH), .DW(DW), .CW(4)) dut4 (
    .aclk(aclk), .rstn(rstn), .data_in(data_in), .start(start), .abort(abort),
    .cont(cont), .chan_mask(chan_mask), .gate_cycles(gate_cycles),
    .settle_cycles(settle_cycles), .res_valid(res_valid4), .res_ready(res_ready),
    .res_chan(res_chan4), .res_count(res_count4), .res_ovf(res_ovf4), .busy(busy4), .done(done4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit lv(input int ch, input int j);
    return ((j + ph[ch]) % per[ch]) < (per[ch] / 2);
  endfunction

  // Rising crossings seen by a gate starting at gs: sample pairs (j, j+1), j = gs-2 .. gs+g-3.
  function automatic int exp_edges(input int ch, input int gs, input int g);
    int n = 0;
    for (int j = gs - 2; j <= gs + g - 3; j++) begin
      if (!lv(ch, j) && lv(ch, j + 1)) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      data_in[ch*DW +: DW] = lv(ch, cyc) ? 8'(THRESH_DEF + 8'($urandom_range(0, 127)))
                                         : 8'($urandom_range(0, 127));
    end
    start = 1'b0;
    abort = 1'b0;
    if (in_run) begin
      chan_mask     = NCH'($urandom);
      gate_cycles   = $urandom;
      settle_cycles = 16'($urandom);
      cont          = 1'($urandom);
      start         = ($urandom_range(0, 7) == 0);
    end
  endtask

  // rdy_mode: 0 always ready, 1 random ready, 2 ready held low for 30 cycles.
  task automatic run_scan(input logic [NCH-1:0] mask, input int gate, input int settle,
                          input bit cnt_mode, input int abort_pass, input int rdy_mode);
    int chs[$];
    int sp, gp, gs, t, ch, e, k;
    sp = (settle < 2) ? 2 : settle;
    gp = (gate == 0) ? 1 : gate;
    for (int c = 0; c < NCH; c++) if (mask[c]) chs.push_back(c);
    chan_mask     = mask;
    gate_cycles   = gate;
    settle_cycles = 16'(settle);
    cont          = cnt_mode;
    start         = 1'b1;
    res_ready     = 1'b0;
    gs = cyc + 1 + sp;
    in_run = 1'b1;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < chs.size(); i++) begin
        ch = chs[i];
        if (pass == abort_pass && i == 0) begin
          while (cyc < gs + gp / 2) step();
          abort  = 1'b1;
          in_run = 1'b0;
          check_eq("abort_cycle_valid", res_valid, 0);
          step();
          check_eq("abort_busy", busy, 0);
          check_eq("abort_valid", res_valid, 0);
          check_eq("abort_done", done, 0);
          step();
          check_eq("abort_no_done", done, 0);
          return;
        end
        while (cyc < gs + gp - 1) step();
        check_eq("valid_before_store", res_valid, 0);
        step();
        e = exp_edges(ch, gs, gp);
        check_eq("res_valid", res_valid, 1);
        check_eq("res_busy", busy, 1);
        check_eq("res_chan", res_chan, ch);
        check_eq("res_count", res_count, e);
        check_eq("res_ovf", res_ovf, 0);
        check_eq("res_valid4", res_valid4, 1);
        check_eq("res_chan4", res_chan4, ch);
        check_eq("res_count4", res_count4, (e > 15) ? 15 : e);
        check_eq("res_ovf4", res_ovf4, (e > 15) ? 1 : 0);
        for (k = 0; k < 100; k++) begin
          case (rdy_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 2) != 0) || (k >= 20);
            default: res_ready = (k >= 30);
          endcase
          if (res_ready) break;
          step();
          check_eq("stall_valid", res_valid, 1);
          check_eq("stall_chan", res_chan, ch);
          check_eq("stall_count", res_count, e);
        end
        t = cyc;
        step();
        check_eq("valid_after_xfer", res_valid, 0);
        if (i == chs.size() - 1 && !cnt_mode) begin
          check_eq("done_early", done, 0);
          in_run    = 1'b0;
          res_ready = 1'b0;
          step();
          check_eq("done_pulse", done, 1);
          check_eq("busy_end", busy, 0);
          step();
          check_eq("done_one_cycle", done, 0);
          return;
        end
        gs = t + 2 + sp;
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      per[c] = 10;
      ph[c]  = 0;
    end
    step();
    step();
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_chan", res_chan, 0);
    check_eq("rst_count", res_count, 0);
    check_eq("rst_ovf", res_ovf, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rstn = 1'b1;
    step();
    step();

    ph[0] = 3;
    run_scan(4'b0001, 100, 4, 1'b0, -1, 0);

    per[0] = 10; per[1] = 20; per[2] = 6; per[3] = 50;
    ph[1] = 7; ph[3] = 11;
    run_scan(4'b1011, 200, 3, 1'b0, -1, 0);

    run_scan(4'b0001, 100, 4, 1'b0, -1, 2);

    per[0] = 2;
    run_scan(4'b0001, 64, 4, 1'b0, -1, 0);

    per[2] = 8;
    run_scan(4'b0100, 40, 3, 1'b1, 1, 0);

    chan_mask = 4'b0000;
    start     = 1'b1;
    step();
    check_eq("empty_done", done, 1);
    check_eq("empty_busy", busy, 0);
    step();
    check_eq("empty_done_once", done, 0);
    chan_mask = 4'b0001;
    start     = 1'b1;
    abort     = 1'b1;
    step();
    check_eq("start_abort_busy", busy, 0);
    step();
    check_eq("start_abort_idle", busy, 0);
    per[1] = 2;
    for (int p = 0; p < 2; p++) begin
      ph[1] = p;
      run_scan(4'b0010, 0, 2, 1'b0, -1, 1);
    end

    per[0] = 2;
    chan_mask = 4'b0001; gate_cycles = 32'd50; settle_cycles = 16'd2; cont = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 12; i++) step();
    #3 rstn = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_valid", res_valid, 0);
    check_eq("arst_count", res_count, 0);
    step();
    rstn = 1'b1;
    step();

    for (int r = 0; r < 8; r++) begin
      bit cm;
      for (int c = 0; c < NCH; c++) begin
        per[c] = $urandom_range(2, 12);
        ph[c]  = $urandom_range(0, 11);
      end
      cm = 1'($urandom);
      run_scan(NCH'($urandom_range(1, 15)), $urandom_range(0, 40), $urandom_range(0, 6),
               cm, cm ? $urandom_range(1, 2) : -1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_scan_ctrl.md
Name: freq_scan_ctrl

Overview:
- Multi-channel frequency-measurement sequencer.
- Shares one threshold-crossing edge counter across NCH 8-bit ADC sample streams, all in the aclk domain.
- Per run: selects each enabled channel in turn, waits a settle window, counts rising threshold crossings over a programmable gate window, then hands the count out on a valid/ready result port.
- Sits between the ADC capture logic and the register/readout block that consumes frequency results.

Parameters:
- NCH, 4: number of ADC channels (2..16).
- DW, 8: ADC sample width.
- CW, 32: result counter width.
- THRESH, 8'h80: a sample is high when `sample >= THRESH` (unsigned).

Ports:
- aclk  in  1  system clock, 50 MHz.
- rstn  in  1  asynchronous active-low reset.
- data_in  in  NCH*DW  packed samples; channel i is `data_in[i*DW +: DW]`.
- start  in  1  one-cycle run request; honoured only in IDLE.
- abort  in  1  stop the current run; highest priority.
- cont  in  1  continuous mode; latched at start.
- chan_mask  in  NCH  channels to scan; latched at start.
- gate_cycles  in  32  gate length in aclk cycles; latched at start; 0 is treated as 1.
- settle_cycles  in  16  settle length; latched at start.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_chan  out  4  channel index of the result.
- res_count  out  CW  rising-crossing count.
- res_ovf  out  1  count saturated during the gate.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a non-continuous run ends normally.

Behaviour:
- Reset: state IDLE; res_valid, res_chan, res_count, res_ovf, busy and done all 0; latched config cleared.
- Edge path:
  - Stage 1 registers `lvl <= (sel_sample >= THRESH)` for the selected channel.
  - Stage 2 registers `lvl_d <= lvl`.
  - An edge occurs when `lvl=1` and `lvl_d=0`.
- State IDLE:
  - start=1 with chan_mask≠0: latch config, select the lowest set mask bit, go to SETTLE.
  - start=1 with chan_mask=0: done pulses the next cycle; stay in IDLE; no result.
- State SETTLE:
  - lvl and lvl_d track the new channel; edges are not counted.
  - Duration is `max(settle_cycles, 2)` cycles, so the pipeline always holds only new-channel data.
  - Then clear the counter and ovf, go to GATE.
- State GATE:
  - Lasts exactly `max(gate_cycles, 1)` cycles.
  - Each cycle with an edge increments the count.
  - At `2^CW-1` the count holds and ovf is set.
  - After the last gate cycle go to STORE. An edge in the last gate cycle is counted.
- State STORE:
  - res_valid=1 from the first STORE cycle, i.e. the cycle after the last gate cycle.
  - res_chan, res_count and res_ovf are stable while valid.
  - A transfer happens when `res_valid && res_ready`. res_valid drops the next cycle and the FSM goes to NEXT.
  - Backpressure stalls the scan indefinitely; input samples are ignored while stalled.
- State NEXT (one cycle):
  - Select the next higher set bit of the latched mask and go to SETTLE.
  - If there is none and cont=1: wrap to the lowest set bit and go to SETTLE.
  - If there is none and cont=0: pulse done, go to IDLE.
- Channel order is strictly ascending within a pass; a single-bit mask re-measures the same channel each pass.
- abort=1 in any state: next cycle state=IDLE, res_valid=0, no done pulse, the current count is discarded.
- abort and start in the same cycle: abort wins; stay in IDLE.
- start while busy is ignored. Changes to config inputs while busy have no effect.
- Asynchronous reset mid-run behaves like abort, plus all outputs are cleared.
- Count arithmetic is unsigned.
  - Gate counter: 32-bit down-counter loaded with `gate_cycles-1`.
  - Settle counter: 16-bit.

Decomposition:
- Package freq_pkg holds:
  - the state enum (IDLE, SETTLE, GATE, STORE, NEXT);
  - CLK_HZ = 50_000_000;
  - GATE_1S = 50_000_000;
  - the default THRESH.
- Sub-module edge_gate_counter:
  - contains the threshold compare, the 2-stage level pipeline, and the saturating CW counter with ovf;
  - controls are clr, cnt_en and sample;
  - the FSM stays in freq_scan_ctrl.

Test Plan:
- Scenario 1: mask=0001, gate=100, settle=4, ch0 square wave period 10 cycles (0xFF/0x00, phase keeps edges off the gate boundary), res_ready=1.
  - Expect exactly one result: res_chan=0, res_count=10, ovf=0.
  - Expect done to pulse once and busy to return low.
- Scenario 2: mask=1011, ch0/1/3 periods 10/20/50, gate=200, cont=0.
  - Expect results in order: (0,20), (1,10), (3,4).
  - Expect no result for ch2, then a done pulse.
- Scenario 3: as scenario 1, with res_ready held low for 30 cycles.
  - Expect res_valid high and all result fields stable for 30 cycles.
  - Expect the transfer on the first ready cycle, with no second result before the next gate.
- Scenario 4: CW parameter overridden to 4, ch0 period 2, gate=64.
  - Expect res_count=15 and res_ovf=1.
- Scenario 5: cont=1, mask=0100, abort asserted mid-GATE of the second pass.
  - Expect exactly one result (chan 2) before the abort.
  - Expect IDLE the next cycle, no done pulse, and a later start accepted.
- Scenario 6: start with mask=0000 → done pulses the next cycle, busy stays 0. start and abort together → stays in IDLE. gate_cycles=0 → a 1-cycle gate.
